// File: rtl/cabin_service_arbiter.sv
// Round-robin arbiter for the shared cabin actuator/annunciation bus.
// Requesters: 0 crew call, 1 cabin lighting, 2 seatbelt sign, 3 PA.
// Grants are bounded by MAX_HOLD. A cooldown gap separates grants.
// Critical flight phases restrict bus ownership to CRIT_MASK requesters.
module cabin_service_arbiter #(
  parameter int unsigned MAX_HOLD        = 8,
  parameter int unsigned COOLDOWN_CYCLES = 1,
  parameter logic [3:0]  CRIT_MASK       = 4'b1100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] flight_phase,
  input  logic       phase_stable,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic       revoked
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_COOLDOWN
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [3:0] CD_LIMIT   = 4'(COOLDOWN_CYCLES);

  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nx;
  logic [1:0] r_gnt_id;
  logic [1:0] w_gnt_id_nx;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_cnt_nx;
  logic [3:0] r_cd_cnt;
  logic [3:0] w_cd_cnt_nx;
  logic       r_timeout;
  logic       w_timeout_nx;
  logic       r_revoked;
  logic       w_revoked_nx;

  logic       w_crit;
  logic [3:0] w_elig;
  logic [1:0] w_cand;
  logic [1:0] w_sel;
  logic       w_sel_valid;

  assign w_crit = (flight_phase == 3'd2) || (flight_phase == 3'd6) || (flight_phase == 3'd7);
  assign w_elig = req & (w_crit ? CRIT_MASK : 4'hF);

  // Rotating-priority search starting just after the last granted index
  always_comb begin
    w_sel       = '0;
    w_sel_valid = 1'b0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_cand = r_gnt_id + 2'(k);
      if (!w_sel_valid && w_elig[w_cand]) begin
        w_sel       = w_cand;
        w_sel_valid = 1'b1;
      end
    end
  end

  // Next-state and next-register values; GRANT checks release, revoke, timeout in that order
  always_comb begin
    w_state_nx    = r_state;
    w_gnt_nx      = r_gnt;
    w_gnt_id_nx   = r_gnt_id;
    w_hold_cnt_nx = r_hold_cnt;
    w_cd_cnt_nx   = r_cd_cnt;
    w_timeout_nx  = 1'b0;
    w_revoked_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (phase_stable && w_sel_valid) begin
          w_state_nx    = S_GRANT;
          w_gnt_nx      = 4'b0001 << w_sel;
          w_gnt_id_nx   = w_sel;
          w_hold_cnt_nx = 8'd1;
        end
      end
      S_GRANT: begin
        if (!req[r_gnt_id]) begin
          w_gnt_nx    = '0;
          w_state_nx  = S_COOLDOWN;
          w_cd_cnt_nx = 4'd1;
        end else if (w_crit && !CRIT_MASK[r_gnt_id]) begin
          w_gnt_nx     = '0;
          w_revoked_nx = 1'b1;
          w_state_nx   = S_COOLDOWN;
          w_cd_cnt_nx  = 4'd1;
        end else if (r_hold_cnt == HOLD_LIMIT) begin
          w_gnt_nx     = '0;
          w_timeout_nx = 1'b1;
          w_state_nx   = S_COOLDOWN;
          w_cd_cnt_nx  = 4'd1;
        end else begin
          w_hold_cnt_nx = r_hold_cnt + 8'd1;
        end
      end
      S_COOLDOWN: begin
        if (r_cd_cnt == CD_LIMIT) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cd_cnt_nx = r_cd_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  // State register; en=0 freezes everything and clears the event pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= 2'd3;
      r_hold_cnt <= '0;
      r_cd_cnt   <= '0;
      r_timeout  <= 1'b0;
      r_revoked  <= 1'b0;
    end else if (en) begin
      r_state    <= w_state_nx;
      r_gnt      <= w_gnt_nx;
      r_gnt_id   <= w_gnt_id_nx;
      r_hold_cnt <= w_hold_cnt_nx;
      r_cd_cnt   <= w_cd_cnt_nx;
      r_timeout  <= w_timeout_nx;
      r_revoked  <= w_revoked_nx;
    end else begin
      r_timeout  <= 1'b0;
      r_revoked  <= 1'b0;
    end
  end

  // Pulses are masked by en so they read 0 for the whole frozen interval
  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = (r_state == S_GRANT);
  assign timeout = r_timeout & en;
  assign revoked = r_revoked & en;

endmodule

// File: tb/tb_cabin_service_arbiter.sv
// Self-checking bench for cabin_service_arbiter with a bus-ownership reference model.
module tb_cabin_service_arbiter;

  localparam int unsigned MAX_HOLD        = 8;
  localparam int unsigned COOLDOWN_CYCLES = 1;
  localparam logic [3:0]  CRIT_MASK       = 4'b1100;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] flight_phase;
  logic       phase_stable;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic       revoked;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus, for how long, and how many idle edges remain
  int m_owner;
  int m_held;
  int m_gap;
  int m_last;
  bit m_to;
  bit m_rv;

  cabin_service_arbiter #(
    .MAX_HOLD(MAX_HOLD),
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
    .CRIT_MASK(CRIT_MASK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .flight_phase(flight_phase),
    .phase_stable(phase_stable),
    .req(req),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .busy(busy),
    .timeout(timeout),
    .revoked(revoked)
  );

  initial forever #5 clk = ~clk;

  function automatic bit crit_of(input logic [2:0] p);
    return (p == 3'd2) || (p == 3'd6) || (p == 3'd7);
  endfunction

  function automatic bit allowed(input int c, input logic [2:0] p);
    if (crit_of(p)) return CRIT_MASK[c];
    return 1'b1;
  endfunction

  function automatic logic [8:0] exp_out();
    logic [3:0] g;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, 2'(m_last), (m_owner >= 0), m_to & en, m_rv & en};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = 3; m_to = 0; m_rv = 0;
  endtask

  // One clock edge worth of the bus rules, using the inputs currently applied
  task automatic model_step();
    m_to = 0;
    m_rv = 0;
    if (!en) return;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1; m_gap = COOLDOWN_CYCLES;
      end else if (!allowed(m_owner, flight_phase)) begin
        m_owner = -1; m_gap = COOLDOWN_CYCLES; m_rv = 1;
      end else if (m_held == MAX_HOLD) begin
        m_owner = -1; m_gap = COOLDOWN_CYCLES; m_to = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (phase_stable) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_owner < 0 && req[c] && allowed(c, flight_phase)) begin
          m_owner = c; m_last = c; m_held = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; flight_phase = 3'd4; phase_stable = 1'b1; req = 4'h0;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if ({gnt, gnt_id, busy, timeout, revoked} !== 9'b0000_11_0_0_0) begin
      n_err++; $display("FAIL reset_state got=%b exp=%b", {gnt, gnt_id, busy, timeout, revoked}, 9'b0000_11_0_0_0);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_grant();
    do_reset();
    flight_phase = 3'd4; phase_stable = 1'b1; en = 1'b1; req = 4'b0010;
    tick();
    n_cmp++;
    if ({gnt, gnt_id, busy} !== {4'b0010, 2'd1, 1'b1}) begin
      n_err++; $display("FAIL basic_first_grant got=%b exp=%b", {gnt, gnt_id, busy}, {4'b0010, 2'd1, 1'b1});
    end
    tick(); tick();
    req = 4'b0000;
    tick();
    n_cmp++;
    if ({gnt, busy} !== 5'b0000_0) begin
      n_err++; $display("FAIL basic_release got=%b exp=%b", {gnt, busy}, 5'b0000_0);
    end
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_err++; $display("FAIL basic_gap got=%b exp=%b", gnt, 4'b0000);
    end
    tick();
    n_cmp++;
    if ({gnt, gnt_id} !== {4'b0010, 2'd1}) begin
      n_err++; $display("FAIL basic_regrant got=%b exp=%b", {gnt, gnt_id}, {4'b0010, 2'd1});
    end
    n_cmp++;
    if ({gnt, gnt_id, busy, timeout, revoked} !== exp_out()) begin
      n_err++; $display("FAIL basic_model got=%b exp=%b", {gnt, gnt_id, busy, timeout, revoked}, exp_out());
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int lens[$];
    int exp_order[5];
    int cur_len;
    int tos;
    logic prev_busy;
    exp_order = '{0, 1, 2, 3, 0};
    cur_len = 0; tos = 0; prev_busy = 1'b0;
    do_reset();
    flight_phase = 3'd4; phase_stable = 1'b1; en = 1'b1; req = 4'hF;
    for (int t = 0; t < 50; t++) begin
      tick();
      n_cmp++;
      if ({gnt, gnt_id, busy, timeout, revoked} !== exp_out()) begin
        n_err++; $display("FAIL rr_model t=%0t got=%b exp=%b", $time, {gnt, gnt_id, busy, timeout, revoked}, exp_out());
      end
      if (busy && !prev_busy) order.push_back(int'(gnt_id));
      if (busy) cur_len++;
      else if (prev_busy) begin lens.push_back(cur_len); cur_len = 0; end
      if (timeout) tos++;
      prev_busy = busy;
    end
    n_cmp++;
    if (order.size() != 5) begin
      n_err++; $display("FAIL rr_grant_count got=%0d exp=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (order[i] != exp_order[i]) begin
          n_err++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
        end
      end
    end
    foreach (lens[i]) begin
      n_cmp++;
      if (lens[i] != MAX_HOLD) begin
        n_err++; $display("FAIL rr_hold_len[%0d] got=%0d exp=%0d", i, lens[i], MAX_HOLD);
      end
    end
    n_cmp++;
    if (tos != 5) begin
      n_err++; $display("FAIL rr_timeouts got=%0d exp=5", tos);
    end
  endtask

  task automatic test_crit_mask();
    do_reset();
    flight_phase = 3'd2; phase_stable = 1'b1; en = 1'b1; req = 4'b0011;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000) begin
        n_err++; $display("FAIL crit_blocked t=%0t got=%b exp=%b", $time, gnt, 4'b0000);
      end
    end
    req = 4'b0111;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_err++; $display("FAIL crit_safety_grant got=%b exp=%b", gnt, 4'b0100);
    end
  endtask

  task automatic test_phase_revoke();
    do_reset();
    flight_phase = 3'd4; phase_stable = 1'b1; en = 1'b1; req = 4'b0010;
    tick(); tick();
    flight_phase = 3'd6;
    tick();
    n_cmp++;
    if ({gnt, revoked, timeout} !== 6'b0000_1_0) begin
      n_err++; $display("FAIL revoke_pulse got=%b exp=%b", {gnt, revoked, timeout}, 6'b0000_1_0);
    end
    tick();
    n_cmp++;
    if ({gnt, revoked} !== 5'b0000_0) begin
      n_err++; $display("FAIL revoke_one_cycle got=%b exp=%b", {gnt, revoked}, 5'b0000_0);
    end
    do_reset();
    flight_phase = 3'd4; req = 4'b0100;
    tick();
    flight_phase = 3'd6;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_cmp++;
      if ({gnt, revoked} !== 5'b0100_0) begin
        n_err++; $display("FAIL revoke_safety_kept got=%b exp=%b", {gnt, revoked}, 5'b0100_0);
      end
    end
  endtask

  task automatic test_stability_freeze();
    int n;
    bit seen;
    do_reset();
    flight_phase = 3'd4; phase_stable = 1'b0; en = 1'b1; req = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000) begin
        n_err++; $display("FAIL unstable_no_grant got=%b exp=%b", gnt, 4'b0000);
      end
    end
    phase_stable = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_err++; $display("FAIL stable_grant got=%b exp=%b", gnt, 4'b0001);
    end
    tick(); tick();
    en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++;
      if ({gnt, busy, timeout} !== 6'b0001_1_0) begin
        n_err++; $display("FAIL freeze_hold got=%b exp=%b", {gnt, busy, timeout}, 6'b0001_1_0);
      end
    end
    en = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (timeout) seen = 1;
    end
    n_cmp++;
    if (!seen || (n + 7) != MAX_HOLD + 5) begin
      n_err++; $display("FAIL freeze_timeout_delay got=%0d exp=%0d seen=%0b", n + 7, MAX_HOLD + 5, seen);
    end
    en = 1'b0;
    #1;
    n_cmp++;
    if ({timeout, revoked} !== 2'b00) begin
      n_err++; $display("FAIL freeze_pulse_masked got=%b exp=%b", {timeout, revoked}, 2'b00);
    end
    en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_cmp++;
      if ({gnt, gnt_id, busy, timeout, revoked} !== exp_out()) begin
        n_err++; $display("FAIL freeze_resume_model got=%b exp=%b", {gnt, gnt_id, busy, timeout, revoked}, exp_out());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    flight_phase = 3'd4; phase_stable = 1'b1; en = 1'b1; req = 4'b0100;
    tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({gnt, gnt_id, busy} !== {4'b0000, 2'd3, 1'b0}) begin
      n_err++; $display("FAIL async_reset got=%b exp=%b", {gnt, gnt_id, busy}, {4'b0000, 2'd3, 1'b0});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1000;
    tick();
    n_cmp++;
    if ({gnt, gnt_id} !== {4'b1000, 2'd3}) begin
      n_err++; $display("FAIL post_reset_grant got=%b exp=%b", {gnt, gnt_id}, {4'b1000, 2'd3});
    end
  endtask

  task automatic test_random();
    do_reset();
    flight_phase = 3'd4; phase_stable = 1'b1; en = 1'b1; req = 4'h0;
    for (int t = 0; t < 600; t++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) flight_phase = 3'($urandom_range(0, 7));
      phase_stable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 11) == 0) req = 4'($urandom_range(0, 15));
      tick();
      n_cmp++;
      if ({gnt, gnt_id, busy, timeout, revoked} !== exp_out()) begin
        n_err++; $display("FAIL random_model t=%0t got=%b exp=%b", $time, {gnt, gnt_id, busy, timeout, revoked}, exp_out());
      end
      n_cmp++;
      if (!$onehot0(gnt)) begin
        n_err++; $display("FAIL random_onehot t=%0t got=%b exp=onehot0", $time, gnt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_crit_mask();
    test_phase_revoke();
    test_stability_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
